// File: rtl/demux1x4_collect_if.sv
// demux1x4_collect_if
// Stream-side and vector-side signals of the 1x4 element collector, grouped
// so the collector and its neighbours share one bundle. The clock and reset
// are not part of the bundle.
// Optional feature macro: DEMUX1X4_ADDR_EN (adds in_sel, the addressed-write slot select).
interface demux1x4_collect_if #(
    parameter int INT_LENGTH  = 5,
    parameter int FRAC_LENGTH = 12
);
    localparam int W = INT_LENGTH + FRAC_LENGTH;

    logic         flush;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] c;
    logic [W-1:0] d;
    logic         out_valid;
    logic         out_ready;
    logic [2:0]   fill_level;
`ifdef DEMUX1X4_ADDR_EN
    logic [1:0]   in_sel;
`endif

`ifdef DEMUX1X4_ADDR_EN
    // Producer/consumer side: drives the element stream and the vector ready
    modport master (
        output flush, in_data, in_valid, in_sel, out_ready,
        input  in_ready, a, b, c, d, out_valid, fill_level
    );

    // Collector side
    modport slave (
        input  flush, in_data, in_valid, in_sel, out_ready,
        output in_ready, a, b, c, d, out_valid, fill_level
    );
`else
    // Producer/consumer side: drives the element stream and the vector ready
    modport master (
        output flush, in_data, in_valid, out_ready,
        input  in_ready, a, b, c, d, out_valid, fill_level
    );

    // Collector side
    modport slave (
        input  flush, in_data, in_valid, out_ready,
        output in_ready, a, b, c, d, out_valid, fill_level
    );
`endif

endinterface

// File: rtl/demux1x4_collect.sv
// demux1x4_collect
// Collects four fixed-point elements from a serial valid/ready stream into
// slots a, b, c, d and offers them as one vector with its own valid/ready.
// Default build fills the slots in order a, b, c, d.
// Optional feature macro: DEMUX1X4_ADDR_EN -- each word carries a slot
// select and the vector completes once every slot has been written.
module demux1x4_collect #(
    parameter int INT_LENGTH  = 5,
    parameter int FRAC_LENGTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    demux1x4_collect_if.slave    bus
);

    localparam int W = INT_LENGTH + FRAC_LENGTH;

    // FILL: still gathering elements; FULL: a..d hold a complete vector
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_FULL = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_next;
    logic [W-1:0] r_slot [4];

    logic         w_out_valid;
    logic         w_in_ready;
    logic         w_accept;
    logic         w_drain;
    logic         w_complete;
    logic [1:0]   w_wr_idx;
    logic [2:0]   w_fill_level;

`ifdef DEMUX1X4_ADDR_EN
    logic [3:0]   r_mask;
    logic [3:0]   w_mask_next;
    logic [3:0]   w_mask_base;
    logic [3:0]   w_sel_onehot;
`else
    logic [1:0]   r_cnt;
    logic [1:0]   w_cnt_next;
`endif

    // Handshake decode shared by both fill modes
    assign w_out_valid = (r_state == ST_FULL);
    assign w_in_ready  = ~w_out_valid | bus.out_ready;
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_drain     = w_out_valid & bus.out_ready;

`ifdef DEMUX1X4_ADDR_EN
    // A drain in the same cycle starts the new word in a fresh mask
    assign w_sel_onehot = 4'b0001 << bus.in_sel;
    assign w_mask_base  = w_drain ? 4'b0000 : r_mask;
    assign w_wr_idx     = bus.in_sel;
    assign w_complete   = w_accept & (&(w_mask_base | w_sel_onehot));
    assign w_fill_level = w_out_valid ? 3'd4
                        : ({2'b00, r_mask[0]} + {2'b00, r_mask[1]}
                         + {2'b00, r_mask[2]} + {2'b00, r_mask[3]});
`else
    // Slot counter is always 0 while a vector is held, so completion and drain never collide
    assign w_wr_idx     = r_cnt;
    assign w_complete   = w_accept & (r_cnt == 2'd3);
    assign w_fill_level = w_out_valid ? 3'd4 : {1'b0, r_cnt};
`endif

`ifdef DEMUX1X4_ADDR_EN
    // Next-state for the vector FSM and the written-slot mask; flush wins over everything
    always_comb begin
        w_state_next = r_state;
        w_mask_next  = r_mask;
        if (bus.flush) begin
            w_state_next = ST_FILL;
            w_mask_next  = 4'b0000;
        end else begin
            if (w_drain) begin
                w_state_next = ST_FILL;
                w_mask_next  = 4'b0000;
            end
            if (w_accept) begin
                w_mask_next = w_mask_base | w_sel_onehot;
                if (w_complete) begin
                    w_state_next = ST_FULL;
                    w_mask_next  = 4'b0000;
                end
            end
        end
    end

    // State and mask registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_state_next;
            r_mask  <= w_mask_next;
        end
    end
`else
    // Next-state for the vector FSM and the slot counter; flush wins over everything
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        if (bus.flush) begin
            w_state_next = ST_FILL;
            w_cnt_next   = 2'd0;
        end else begin
            if (w_drain) begin
                w_state_next = ST_FILL;
            end
            if (w_accept) begin
                w_cnt_next = r_cnt + 2'd1;
                if (w_complete) begin
                    w_state_next = ST_FULL;
                end
            end
        end
    end

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
            r_cnt   <= 2'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end
`endif

    // Element slots: store accepted words bit-exact, a flushed word is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_slot[i] <= '0;
            end
        end else if (w_accept && !bus.flush) begin
            r_slot[w_wr_idx] <= bus.in_data;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.fill_level = w_fill_level;
    assign bus.a          = r_slot[0];
    assign bus.b          = r_slot[1];
    assign bus.c          = r_slot[2];
    assign bus.d          = r_slot[3];

endmodule

// File: tb/tb_demux1x4_collect.sv
// tb_demux1x4_collect
// Directed bench for demux1x4_collect: reset, in-order fill, stall while full,
// same-cycle drain and accept, flush, asynchronous mid-vector reset and,
// when DEMUX1X4_ADDR_EN is defined, addressed slot writes.
module tb_demux1x4_collect;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    demux1x4_collect_if #(.INT_LENGTH(5), .FRAC_LENGTH(12)) bus ();

    demux1x4_collect #(.INT_LENGTH(5), .FRAC_LENGTH(12)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present one word for exactly one rising edge, then leave in_valid low
    task automatic push(input logic [16:0] data, input logic [1:0] sel);
        bus.in_valid = 1'b1;
        bus.in_data  = data;
`ifdef DEMUX1X4_ADDR_EN
        bus.in_sel   = sel;
`else
        if (sel == 2'd0) begin
            bus.in_valid = 1'b1;
        end
`endif
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Asynchronous reset values, then in_ready after release
    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        checks++; if (bus.a !== 17'h0) begin errors++; $display("[TB] FAIL reset_a: got %h expected %h", bus.a, 17'h0); end
        checks++; if (bus.b !== 17'h0) begin errors++; $display("[TB] FAIL reset_b: got %h expected %h", bus.b, 17'h0); end
        checks++; if (bus.c !== 17'h0) begin errors++; $display("[TB] FAIL reset_c: got %h expected %h", bus.c, 17'h0); end
        checks++; if (bus.d !== 17'h0) begin errors++; $display("[TB] FAIL reset_d: got %h expected %h", bus.d, 17'h0); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("[TB] FAIL reset_fill: got %0d expected 0", bus.fill_level); end
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    endtask

    // Four back-to-back words with the consumer stalled
    task automatic test_stream();
        bus.out_ready = 1'b0;
        push(17'h00100, 2'd0);
        push(17'h1FF00, 2'd1);
        push(17'h00001, 2'd2);
        checks++; if (bus.fill_level !== 3'd3) begin errors++; $display("[TB] FAIL stream_fill3: got %0d expected 3", bus.fill_level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL stream_early_valid: got %b expected 0", bus.out_valid); end
        push(17'h0ABCD, 2'd3);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stream_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.a !== 17'h00100) begin errors++; $display("[TB] FAIL stream_a: got %h expected %h", bus.a, 17'h00100); end
        checks++; if (bus.b !== 17'h1FF00) begin errors++; $display("[TB] FAIL stream_b: got %h expected %h", bus.b, 17'h1FF00); end
        checks++; if (bus.c !== 17'h00001) begin errors++; $display("[TB] FAIL stream_c: got %h expected %h", bus.c, 17'h00001); end
        checks++; if (bus.d !== 17'h0ABCD) begin errors++; $display("[TB] FAIL stream_d: got %h expected %h", bus.d, 17'h0ABCD); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stream_in_ready: got %b expected 0", bus.in_ready); end
        checks++; if (bus.fill_level !== 3'd4) begin errors++; $display("[TB] FAIL stream_fill4: got %0d expected 4", bus.fill_level); end
        @(posedge clk);
        #1;
        checks++; if (bus.fill_level !== 3'd4) begin errors++; $display("[TB] FAIL stream_fill4_held: got %0d expected 4", bus.fill_level); end
    endtask

    // Producer holds a word while the collector is full and the consumer stalls
    task automatic test_stall();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 17'h12345;
`ifdef DEMUX1X4_ADDR_EN
        bus.in_sel    = 2'd0;
`endif
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("[TB] FAIL stall_in_ready[%0d]: got %b expected 0", i, bus.in_ready); end
            checks++; if (bus.a !== 17'h00100) begin errors++; $display("[TB] FAIL stall_a[%0d]: got %h expected %h", i, bus.a, 17'h00100); end
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.b !== 17'h1FF00) begin errors++; $display("[TB] FAIL stall_b: got %h expected %h", bus.b, 17'h1FF00); end
        checks++; if (bus.c !== 17'h00001) begin errors++; $display("[TB] FAIL stall_c: got %h expected %h", bus.c, 17'h00001); end
        checks++; if (bus.d !== 17'h0ABCD) begin errors++; $display("[TB] FAIL stall_d: got %h expected %h", bus.d, 17'h0ABCD); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_out_valid: got %b expected 1", bus.out_valid); end
    endtask

    // Drain the full vector and accept a new first element on the same edge
    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 17'h00042;
`ifdef DEMUX1X4_ADDR_EN
        bus.in_sel    = 2'd0;
`endif
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("[TB] FAIL b2b_in_ready: got %b expected 1", bus.in_ready); end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.a !== 17'h00042) begin errors++; $display("[TB] FAIL b2b_a: got %h expected %h", bus.a, 17'h00042); end
        checks++; if (bus.b !== 17'h1FF00) begin errors++; $display("[TB] FAIL b2b_b_stale: got %h expected %h", bus.b, 17'h1FF00); end
        checks++; if (bus.fill_level !== 3'd1) begin errors++; $display("[TB] FAIL b2b_fill: got %0d expected 1", bus.fill_level); end
    endtask

    // Flush drops the partial vector and a same-cycle word, then refill from slot a
    task automatic test_flush();
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("[TB] FAIL flush_idle_fill: got %0d expected 0", bus.fill_level); end
        push(17'h11111, 2'd0);
        push(17'h02222, 2'd1);
        checks++; if (bus.fill_level !== 3'd2) begin errors++; $display("[TB] FAIL flush_pre_fill: got %0d expected 2", bus.fill_level); end
        bus.flush    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 17'h1DEAD;
`ifdef DEMUX1X4_ADDR_EN
        bus.in_sel   = 2'd2;
`endif
        @(posedge clk);
        #1;
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("[TB] FAIL flush_fill: got %0d expected 0", bus.fill_level); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.a !== 17'h11111) begin errors++; $display("[TB] FAIL flush_a_held: got %h expected %h", bus.a, 17'h11111); end
        checks++; if (bus.c !== 17'h00001) begin errors++; $display("[TB] FAIL flush_word_dropped: got %h expected %h", bus.c, 17'h00001); end
        push(17'h00A01, 2'd0);
        push(17'h00B02, 2'd1);
        push(17'h00C03, 2'd2);
        push(17'h00D04, 2'd3);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL refill_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.a !== 17'h00A01) begin errors++; $display("[TB] FAIL refill_a: got %h expected %h", bus.a, 17'h00A01); end
        checks++; if (bus.b !== 17'h00B02) begin errors++; $display("[TB] FAIL refill_b: got %h expected %h", bus.b, 17'h00B02); end
        checks++; if (bus.c !== 17'h00C03) begin errors++; $display("[TB] FAIL refill_c: got %h expected %h", bus.c, 17'h00C03); end
        checks++; if (bus.d !== 17'h00D04) begin errors++; $display("[TB] FAIL refill_d: got %h expected %h", bus.d, 17'h00D04); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL drain_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("[TB] FAIL drain_fill: got %0d expected 0", bus.fill_level); end
    endtask

    // Reset pulled low between clock edges with a partial vector in flight
    task automatic test_mid_reset();
        push(17'h01111, 2'd0);
        push(17'h02222, 2'd1);
        push(17'h03333, 2'd2);
        checks++; if (bus.fill_level !== 3'd3) begin errors++; $display("[TB] FAIL midrst_pre_fill: got %0d expected 3", bus.fill_level); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.a !== 17'h0) begin errors++; $display("[TB] FAIL midrst_a: got %h expected %h", bus.a, 17'h0); end
        checks++; if (bus.b !== 17'h0) begin errors++; $display("[TB] FAIL midrst_b: got %h expected %h", bus.b, 17'h0); end
        checks++; if (bus.c !== 17'h0) begin errors++; $display("[TB] FAIL midrst_c: got %h expected %h", bus.c, 17'h0); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("[TB] FAIL midrst_fill: got %0d expected 0", bus.fill_level); end
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("[TB] FAIL midrst_post_fill: got %0d expected 0", bus.fill_level); end
    endtask

`ifdef DEMUX1X4_ADDR_EN
    // Addressed writes with a repeated slot; completes only when all four are written
    task automatic test_addr();
        push(17'd1, 2'd3);
        push(17'd2, 2'd1);
        checks++; if (bus.fill_level !== 3'd2) begin errors++; $display("[TB] FAIL addr_fill2: got %0d expected 2", bus.fill_level); end
        push(17'd3, 2'd1);
        checks++; if (bus.fill_level !== 3'd2) begin errors++; $display("[TB] FAIL addr_rewrite_fill: got %0d expected 2", bus.fill_level); end
        push(17'd4, 2'd0);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("[TB] FAIL addr_early_valid: got %b expected 0", bus.out_valid); end
        checks++; if (bus.fill_level !== 3'd3) begin errors++; $display("[TB] FAIL addr_fill3: got %0d expected 3", bus.fill_level); end
        push(17'd5, 2'd2);
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("[TB] FAIL addr_out_valid: got %b expected 1", bus.out_valid); end
        checks++; if (bus.a !== 17'd4) begin errors++; $display("[TB] FAIL addr_a: got %h expected %h", bus.a, 17'd4); end
        checks++; if (bus.b !== 17'd3) begin errors++; $display("[TB] FAIL addr_b: got %h expected %h", bus.b, 17'd3); end
        checks++; if (bus.c !== 17'd5) begin errors++; $display("[TB] FAIL addr_c: got %h expected %h", bus.c, 17'd5); end
        checks++; if (bus.d !== 17'd1) begin errors++; $display("[TB] FAIL addr_d: got %h expected %h", bus.d, 17'd1); end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checks++; if (bus.fill_level !== 3'd0) begin errors++; $display("[TB] FAIL addr_drain_fill: got %0d expected 0", bus.fill_level); end
    endtask
`endif

    // Scenario sequence
    initial begin
        errors        = 0;
        checks        = 0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
`ifdef DEMUX1X4_ADDR_EN
        bus.in_sel    = 2'd0;
`endif
        $display("[TB] demux1x4_collect directed test start");
        test_reset();
        test_stream();
        test_stall();
        test_back_to_back();
        test_flush();
        test_mid_reset();
`ifdef DEMUX1X4_ADDR_EN
        test_addr();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
